// File: rtl/ahb_params_pkg.sv
// Shared AHB encodings, the slave FSM state type and the byte-lane decode
// used by the AHB memory slave.
package ahb_params_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Little-endian lane mask for a 32-bit bus from transfer size and offset.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] offs);
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << offs;
      HSIZE_HALF: lane_mask = offs[1] ? 4'b1100 : 4'b0011;
      default:    lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised storage with per-byte write enables: synchronous write,
// combinational read.
module ahb_sram_array #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 256,
  localparam int IDX_W      = $clog2(DEPTH),
  localparam int NB         = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [NB-1:0]         be_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset so it maps onto plain RAM; contents survive
  // a bus reset. Non-blocking writes keep same-edge readers race-free.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: programmable wait states, two-cycle ERROR response
// for out-of-range or misaligned transfers, back-to-back pipelining.
module ahb_mem_slave
  import ahb_params_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int NB    = DATA_WIDTH / 8;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             active_q, active_d;
  logic [IDX_W+1:0] addr_q;
  logic             write_q;
  logic [2:0]       size_q;

  logic                  is_xfer, bad, ready, done, accept;
  logic [DATA_WIDTH-1:0] rdata;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    is_xfer = 1'b0;
    case (HTRANS)
      HTRANS_NONSEQ, HTRANS_SEQ: is_xfer = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  is_xfer = 1'b0;
      default:                   is_xfer = 1'b0;
    endcase
  end

  assign bad = ((HADDR >> 2) >= ADDR_WIDTH'(MEM_DEPTH))
            || (HSIZE > HSIZE_WORD)
            || ((HSIZE == HSIZE_HALF) && HADDR[0])
            || ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));

  assign ready  = (state_q == ST_IDLE) || (state_q == ST_ERR2)
               || ((state_q == ST_WAIT) && (cnt_q == 4'd0));
  assign done   = ((state_q == ST_IDLE) && active_q)
               || ((state_q == ST_WAIT) && (cnt_q == 4'd0));
  assign accept = HSEL && HREADY && ready && is_xfer;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = 1'b0;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end else if (accept) begin
      if (bad) begin
        state_d = ST_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_d = ST_WAIT;
        cnt_d   = 4'(WAIT_STATES);
      end else begin
        state_d  = ST_IDLE;
        active_d = 1'b1;
      end
    end else begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      active_q <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= 3'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      if (accept) begin
        addr_q  <= HADDR[IDX_W+1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
    end
  end

  // Erroring transfers never reach a completing OKAY phase, so they never write.
  ahb_sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH)
  ) u_sram (
    .clk     (HCLK),
    .we_i    (done && write_q),
    .be_i    (NB'(lane_mask(size_q, addr_q[1:0]))),
    .waddr_i (addr_q[IDX_W+1:2]),
    .wdata_i (HWDATA),
    .raddr_i (addr_q[IDX_W+1:2]),
    .rdata_o (rdata)
  );

  assign HREADYOUT = ready;
  assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = done ? rdata : '0;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench: one slave with a single wait state, one with zero wait states,
// sharing the address/control bus and selected individually.
module tb_ahb_mem_slave;
  import ahb_params_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        hsel1, hsel0;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] rd1, rd0;
  logic        rdy1, rdy0, rsp1, rsp0;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] r_rd, r_rdw;
  logic        r_resp, r_respw;
  int          r_waits;

  always #5 HCLK = ~HCLK;

  ahb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(1)) dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdy1),
    .HRDATA(rd1), .HREADYOUT(rdy1), .HRESP(rsp1));

  ahb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdy0),
    .HRDATA(rd0), .HREADYOUT(rdy0), .HRESP(rsp0));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One non-pipelined transfer to dut1 (d=1) or dut0 (d=0); results land in r_*.
  task automatic xfer(input bit d, input bit wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wd);
    bit got;
    hsel1 = d; hsel0 = !d; htrans = HTRANS_NONSEQ; haddr = addr; hwrite = wr; hsize = size;
    @(posedge HCLK); #1;
    hsel1 = 1'b0; hsel0 = 1'b0; htrans = HTRANS_IDLE; hwdata = wd;
    got = 1'b0; r_waits = 0; r_rd = '0; r_rdw = '0; r_resp = 1'b0; r_respw = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge HCLK);
      if ((d ? rdy1 : rdy0) === 1'b1) begin
        got = 1'b1; r_rd = d ? rd1 : rd0; r_resp = d ? rsp1 : rsp0;
      end else begin
        r_waits++; r_rdw = d ? rd1 : rd0; r_respw = d ? rsp1 : rsp0;
      end
    end
    n_cmp++;
    if (!got) begin n_mis++; $display("FAIL xfer_timeout addr=%h: got no HREADYOUT want completion", addr); end
    @(posedge HCLK); #1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; hsel1 = 1'b1; hsel0 = 1'b1; htrans = HTRANS_NONSEQ;
    haddr = 32'h0; hwrite = 1'b0; hsize = HSIZE_WORD; hwdata = 32'h0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    n_cmp++; if (rdy1 !== 1'b1)  begin n_mis++; $display("FAIL rst_ready1: got %b want 1", rdy1); end
    n_cmp++; if (rsp1 !== 1'b0)  begin n_mis++; $display("FAIL rst_resp1: got %b want 0", rsp1); end
    n_cmp++; if (rd1 !== 32'h0)  begin n_mis++; $display("FAIL rst_rdata1: got %h want 0", rd1); end
    n_cmp++; if (rdy0 !== 1'b1)  begin n_mis++; $display("FAIL rst_ready0: got %b want 1", rdy0); end
    n_cmp++; if (rsp0 !== 1'b0)  begin n_mis++; $display("FAIL rst_resp0: got %b want 0", rsp0); end
    n_cmp++; if (rd0 !== 32'h0)  begin n_mis++; $display("FAIL rst_rdata0: got %h want 0", rd0); end
    @(posedge HCLK); #1;
    hsel1 = 1'b0; hsel0 = 1'b0; htrans = HTRANS_IDLE;
    HRESETn = 1'b1;
  endtask

  // Starts right after reset release: write is accepted on the very next edge.
  task automatic test_back_to_back();
    hsel1 = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h10; hwrite = 1'b1; hsize = HSIZE_WORD;
    @(posedge HCLK); #1;
    hwdata = 32'hDEADBEEF; hwrite = 1'b0;
    @(negedge HCLK);
    n_cmp++; if (rdy1 !== 1'b0) begin n_mis++; $display("FAIL b2b_wr_wait: got %b want 0", rdy1); end
    @(posedge HCLK); #1;
    @(negedge HCLK);
    n_cmp++; if (rdy1 !== 1'b1) begin n_mis++; $display("FAIL b2b_wr_done: got %b want 1", rdy1); end
    n_cmp++; if (rsp1 !== 1'b0) begin n_mis++; $display("FAIL b2b_wr_resp: got %b want 0", rsp1); end
    @(posedge HCLK); #1;
    hsel1 = 1'b0; htrans = HTRANS_IDLE;
    @(negedge HCLK);
    n_cmp++; if (rdy1 !== 1'b0) begin n_mis++; $display("FAIL b2b_rd_wait: got %b want 0", rdy1); end
    n_cmp++; if (rd1 !== 32'h0) begin n_mis++; $display("FAIL b2b_rd_wait_data: got %h want 0", rd1); end
    @(posedge HCLK); #1;
    @(negedge HCLK);
    n_cmp++; if (rdy1 !== 1'b1) begin n_mis++; $display("FAIL b2b_rd_done: got %b want 1", rdy1); end
    n_cmp++; if (rd1 !== 32'hDEADBEEF) begin n_mis++; $display("FAIL b2b_rd_data: got %h want deadbeef", rd1); end
    n_cmp++; if (rsp1 !== 1'b0) begin n_mis++; $display("FAIL b2b_rd_resp: got %b want 0", rsp1); end
    @(posedge HCLK); #1;
    @(negedge HCLK);
    n_cmp++; if (rd1 !== 32'h0) begin n_mis++; $display("FAIL b2b_idle_data: got %h want 0", rd1); end
    @(posedge HCLK); #1;
  endtask

  task automatic test_byte_lanes();
    xfer(1'b1, 1'b1, 32'h10, HSIZE_WORD, 32'h11223344);
    n_cmp++; if (r_waits != 1) begin n_mis++; $display("FAIL lane_wr_waits: got %0d want 1", r_waits); end
    xfer(1'b1, 1'b1, 32'h13, HSIZE_BYTE, 32'hAA000000);
    xfer(1'b1, 1'b0, 32'h10, HSIZE_WORD, 32'h0);
    n_cmp++; if (r_rd !== 32'hAA223344) begin n_mis++; $display("FAIL lane_byte3: got %h want aa223344", r_rd); end
    xfer(1'b1, 1'b1, 32'h14, HSIZE_WORD, 32'h55667788);
    xfer(1'b1, 1'b1, 32'h16, HSIZE_HALF, 32'hBEEF0000);
    xfer(1'b1, 1'b1, 32'h15, HSIZE_BYTE, 32'h0000CC00);
    xfer(1'b1, 1'b0, 32'h14, HSIZE_WORD, 32'h0);
    n_cmp++; if (r_rd !== 32'hBEEFCC88) begin n_mis++; $display("FAIL lane_half_byte1: got %h want beefcc88", r_rd); end
    n_cmp++; if (r_resp !== 1'b0) begin n_mis++; $display("FAIL lane_resp: got %b want 0", r_resp); end
  endtask

  task automatic test_error_addr();
    xfer(1'b1, 1'b1, 32'h00, HSIZE_WORD, 32'hCAFEF00D);
    xfer(1'b1, 1'b1, 32'h3FC, HSIZE_WORD, 32'h0BADCAFE);
    xfer(1'b1, 1'b0, 32'h3FC, HSIZE_WORD, 32'h0);
    n_cmp++; if (r_rd !== 32'h0BADCAFE || r_resp !== 1'b0) begin n_mis++; $display("FAIL last_word: got %h/%b want 0badcafe/0", r_rd, r_resp); end
    xfer(1'b1, 1'b0, 32'h400, HSIZE_WORD, 32'h0);
    n_cmp++; if (r_waits != 1) begin n_mis++; $display("FAIL oob_err1_cycles: got %0d want 1", r_waits); end
    n_cmp++; if (r_respw !== 1'b1) begin n_mis++; $display("FAIL oob_err1_resp: got %b want 1", r_respw); end
    n_cmp++; if (r_resp !== 1'b1) begin n_mis++; $display("FAIL oob_err2_resp: got %b want 1", r_resp); end
    n_cmp++; if (r_rd !== 32'h0 || r_rdw !== 32'h0) begin n_mis++; $display("FAIL oob_rdata: got %h,%h want 0,0", r_rdw, r_rd); end
    xfer(1'b1, 1'b1, 32'h400, HSIZE_WORD, 32'h12345678);
    n_cmp++; if (r_resp !== 1'b1) begin n_mis++; $display("FAIL oob_wr_resp: got %b want 1", r_resp); end
    xfer(1'b1, 1'b0, 32'h00, HSIZE_WORD, 32'h0);
    n_cmp++; if (r_rd !== 32'hCAFEF00D) begin n_mis++; $display("FAIL oob_mem_kept: got %h want cafef00d", r_rd); end
  endtask

  task automatic test_error_align();
    xfer(1'b1, 1'b1, 32'h01, HSIZE_HALF, 32'hFFFFFFFF);
    n_cmp++; if (r_waits != 1 || r_respw !== 1'b1 || r_resp !== 1'b1) begin n_mis++;
      $display("FAIL half_misalign: got waits=%0d resp=%b,%b want 1 1,1", r_waits, r_respw, r_resp); end
    xfer(1'b1, 1'b1, 32'h00, 3'd3, 32'hFFFFFFFF);
    n_cmp++; if (r_resp !== 1'b1) begin n_mis++; $display("FAIL size3_resp: got %b want 1", r_resp); end
    xfer(1'b1, 1'b1, 32'h02, HSIZE_WORD, 32'hFFFFFFFF);
    n_cmp++; if (r_resp !== 1'b1) begin n_mis++; $display("FAIL word_misalign: got %b want 1", r_resp); end
    xfer(1'b1, 1'b0, 32'h00, HSIZE_WORD, 32'h0);
    n_cmp++; if (r_rd !== 32'hCAFEF00D) begin n_mis++; $display("FAIL align_mem_kept: got %h want cafef00d", r_rd); end
    xfer(1'b1, 1'b0, 32'h02, HSIZE_HALF, 32'h0);
    n_cmp++; if (r_rd !== 32'hCAFEF00D || r_resp !== 1'b0) begin n_mis++; $display("FAIL half_aligned_rd: got %h/%b want cafef00d/0", r_rd, r_resp); end
  endtask

  task automatic test_zero_wait();
    xfer(1'b0, 1'b1, 32'h00, HSIZE_WORD, 32'hA0A0A0A0);
    n_cmp++; if (r_waits != 0) begin n_mis++; $display("FAIL zw_wr_waits: got %0d want 0", r_waits); end
    xfer(1'b0, 1'b1, 32'h04, HSIZE_WORD, 32'hB4B4B4B4);
    xfer(1'b0, 1'b1, 32'h08, HSIZE_WORD, 32'hC8C8C8C8);
    hsel0 = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b0; hsize = HSIZE_WORD; haddr = 32'h00;
    @(posedge HCLK); #1;
    haddr = 32'h04;
    @(negedge HCLK);
    n_cmp++; if (rdy0 !== 1'b1 || rd0 !== 32'hA0A0A0A0) begin n_mis++; $display("FAIL zw_rd0: got %b/%h want 1/a0a0a0a0", rdy0, rd0); end
    @(posedge HCLK); #1;
    haddr = 32'h08;
    @(negedge HCLK);
    n_cmp++; if (rdy0 !== 1'b1 || rd0 !== 32'hB4B4B4B4) begin n_mis++; $display("FAIL zw_rd4: got %b/%h want 1/b4b4b4b4", rdy0, rd0); end
    @(posedge HCLK); #1;
    hsel0 = 1'b0; htrans = HTRANS_IDLE;
    @(negedge HCLK);
    n_cmp++; if (rdy0 !== 1'b1 || rd0 !== 32'hC8C8C8C8) begin n_mis++; $display("FAIL zw_rd8: got %b/%h want 1/c8c8c8c8", rdy0, rd0); end
    @(posedge HCLK); #1;
  endtask

  task automatic test_reset_mid();
    xfer(1'b1, 1'b1, 32'h20, HSIZE_WORD, 32'h01020304);
    hsel1 = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h20; hwrite = 1'b1; hsize = HSIZE_WORD;
    @(posedge HCLK); #1;
    hsel1 = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hFFFFFFFF;
    n_cmp++; if (rdy1 !== 1'b0) begin n_mis++; $display("FAIL mid_in_wait: got %b want 0", rdy1); end
    #1 HRESETn = 1'b0;
    #1;
    n_cmp++; if (rdy1 !== 1'b1 || rsp1 !== 1'b0 || rd1 !== 32'h0) begin n_mis++;
      $display("FAIL mid_rst_outputs: got %b/%b/%h want 1/0/0", rdy1, rsp1, rd1); end
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    hsel1 = 1'b1; htrans = HTRANS_IDLE;
    for (int i = 0; i < 2; i++) begin
      @(negedge HCLK);
      n_cmp++; if (rdy1 !== 1'b1 || rsp1 !== 1'b0) begin n_mis++; $display("FAIL mid_idle_%0d: got %b/%b want 1/0", i, rdy1, rsp1); end
      @(posedge HCLK); #1;
      htrans = HTRANS_BUSY;
    end
    hsel1 = 1'b0; htrans = HTRANS_IDLE;
    xfer(1'b1, 1'b0, 32'h20, HSIZE_WORD, 32'h0);
    n_cmp++; if (r_rd !== 32'h01020304) begin n_mis++; $display("FAIL mid_mem_kept: got %h want 01020304", r_rd); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_byte_lanes();
    test_error_addr();
    test_error_align();
    test_zero_wait();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ahb_mem_slave.md
AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 Parameters:
- DATA_WIDTH, default 32, data bus width.
- ADDR_WIDTH, default 32, HADDR width.
- MEM_DEPTH, default 256, number of DATA_WIDTH words.
- WAIT_STATES, default 1 (range 0..15), HREADYOUT-low cycles per OKAY data phase.

REQ-002 Ports, one clock; reset is asynchronous and active-low:
- HCLK, in, 1, clock.
- HRESETn, in, 1, asynchronous active-low reset.
- HSEL, in, 1, decoder select for this slave.
- HADDR, in, ADDR_WIDTH, byte address.
- HTRANS, in, 2, transfer type.
- HWRITE, in, 1, 1 = write.
- HSIZE, in, 3, transfer size.
- HWDATA, in, DATA_WIDTH, write data (data phase).
- HREADY, in, 1, bus-level ready from the response mux.
- HRDATA, out, DATA_WIDTH, read data to the response mux.
- HREADYOUT, out, 1, slave ready to the response mux.
- HRESP, out, 1, 0 = OKAY, 1 = ERROR.

Function
REQ-003 An address phase is accepted on a rising HCLK edge when HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ. On acceptance, HADDR, HWRITE and HSIZE are registered for the data phase.

REQ-004 With HSEL=0, or HTRANS IDLE/BUSY when sampled, the next cycle is a zero-wait OKAY response: HREADYOUT=1, HRESP=0.

REQ-005 An accepted transfer is an error if any of the following hold:
- word index (HADDR >> 2) >= MEM_DEPTH;
- HSIZE > 2;
- halfword with HADDR[0]=1;
- word with HADDR[1:0] != 0.

REQ-006 FSM states:
- IDLE: no transfer pending.
- WAIT: counting wait states.
- ERR1: first cycle of ERROR response.
- ERR2: second cycle of ERROR response.

REQ-007 IDLE transitions on acceptance:
- error -> ERR1;
- else WAIT_STATES > 0 -> WAIT with counter = WAIT_STATES;
- else the data phase completes in the next cycle while the FSM stays in IDLE.

REQ-008 In WAIT, HREADYOUT=0 and the counter decrements each cycle. When the counter reaches 0, the next cycle drives HREADYOUT=1 to complete the data phase.

REQ-009 In ERR1, HRESP=1 and HREADYOUT=0. ERR2 always follows ERR1 and drives HRESP=1, HREADYOUT=1. This two-cycle ERROR response is mandatory.

REQ-010 A write commits to memory only on the data-phase completion edge (HREADYOUT=1, OKAY). HWDATA is sampled on that edge.

REQ-011 Write byte lanes are little-endian, selected by the registered HSIZE and HADDR[1:0]:
- byte: 1 lane;
- halfword: lanes [1:0] or [3:2];
- word: all lanes.
Unselected bytes are unchanged.

REQ-012 Read data: HRDATA = mem[registered word index] during the completing cycle. HRDATA is 0 in every other cycle and on ERROR.

REQ-013 A new address phase is accepted in the same cycle a data phase completes (HREADYOUT=1, HREADY=1), so back-to-back transfers add no idle cycle.

REQ-014 A read following a write to the same word returns the newly written data, with no extra wait state.

REQ-015 An erroring write never modifies memory.

REQ-016 Address phases presented while HREADYOUT=0 are not accepted.

Reset
REQ-017 While HRESETn=0:
- state = IDLE;
- counter = 0;
- registered address/control = 0;
- HRDATA = 0, HREADYOUT = 1, HRESP = 0.

REQ-018 Reset asserted mid-transfer abandons the transfer, and any pending write is discarded. Memory contents are not reset.

REQ-019 The first transfer can be accepted on the first rising edge after HRESETn deasserts.

Structure
REQ-020 ahb_params_pkg holds:
- HTRANS encodings: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3;
- HSIZE codes;
- HRESP OKAY/ERROR;
- the FSM state enum.

REQ-021 The storage array with byte-lane write enables is one sub-module, ahb_sram_array. It has a synchronous write and a combinational read port, and no reset.

Verification
REQ-022 WAIT_STATES=1: word write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> each data phase shows HREADYOUT low for 1 cycle; read returns 0xDEADBEEF, HRESP=0.

REQ-023 Byte write 0xAA to 0x13 over word 0x11223344 -> read 0x10 returns 0xAA223344.

REQ-024 Read 0x400 with MEM_DEPTH=256 -> HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1; HRDATA=0; memory unchanged.

REQ-025 Halfword write to 0x01 -> two-cycle ERROR; subsequent read of 0x00 returns the prior value.

REQ-026 WAIT_STATES=0: back-to-back NONSEQ reads of 0x00, 0x04, 0x08 -> HREADYOUT stays 1; data is returned in consecutive cycles.

REQ-027 Assert HRESETn low during a WAIT-state write to 0x20 -> outputs immediately HREADYOUT=1, HRESP=0, HRDATA=0; word 0x20 unchanged; IDLE transfers after release get zero-wait OKAY.
